// File: rtl/snake_pkg.sv
// Shared playfield geometry, food-generator state encoding and index/XY helper,
// used by the food generator and by the rest of the game logic.
package snake_pkg;

  localparam int unsigned GRID_W  = 10;
  localparam int unsigned GRID_H  = 9;
  localparam int unsigned N_CELLS = GRID_W * GRID_H;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2,
    FULL = 2'd3
  } food_state_t;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } cell_xy_t;

  // Only ever evaluated on the accepted start cell; the scan loop steps X/Y incrementally.
  function automatic cell_xy_t idx_to_xy(input logic [6:0] idx, input int unsigned w);
    cell_xy_t    r;
    int unsigned i;
    i   = 32'(idx);
    r.x = 4'(i % w);
    r.y = 4'(i / w);
    return r;
  endfunction

endpackage

// File: rtl/snake_lfsr7.sv
// Free-running 7-bit Fibonacci LFSR (x^7 + x^6 + 1, period 127), reloaded with
// SEED while reset is held.
module snake_lfsr7 #(
  parameter logic [6:0] SEED = 7'h2D
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  output logic [6:0] o_Value
);

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      o_Value <= SEED;
    end else begin
      o_Value <= {o_Value[5:0], o_Value[6] ^ o_Value[5]};
    end
  end

endmodule

// File: rtl/snake_food_gen.sv
// Food placement: pick a pseudo-random start cell, then linearly probe the
// snapshotted body bitmap one cell per cycle until a free cell or a full board.
module snake_food_gen
  import snake_pkg::*;
#(
  parameter int unsigned GRID_W    = snake_pkg::GRID_W,
  parameter int unsigned GRID_H    = snake_pkg::GRID_H,
  parameter logic [6:0]  LFSR_SEED = 7'h2D
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst_L,
  input  logic                       i_Req,
  input  logic [GRID_W*GRID_H-1:0]   i_Body,
  output logic                       o_Busy,
  output logic                       o_Valid,
  output logic                       o_Full,
  output logic [3:0]                 o_Food_X,
  output logic [3:0]                 o_Food_Y,
  output logic [6:0]                 o_Food_Idx
);

  localparam int unsigned NC = GRID_W * GRID_H;

  food_state_t     state, state_nxt;
  logic [6:0]      lfsr_val;
  logic [NC-1:0]   body_snap;
  logic [6:0]      cand_idx;
  logic [3:0]      cand_x, cand_y;
  logic [6:0]      probe_cnt;
  logic [6:0]      probe_nxt;
  logic [6:0]      start_idx;
  cell_xy_t        start_xy;
  logic            cand_occ;

  snake_lfsr7 #(.SEED(LFSR_SEED)) u_lfsr (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .o_Value (lfsr_val)
  );

  // Fold the 1..127 LFSR range onto the board with a single conditional subtract.
  always_comb begin
    start_idx = (lfsr_val < 7'(NC)) ? lfsr_val : lfsr_val - 7'(NC);
    start_xy  = idx_to_xy(start_idx, GRID_W);
    cand_occ  = body_snap[cand_idx];
    probe_nxt = probe_cnt + 7'd1;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (i_Req) state_nxt = SCAN;
      SCAN: begin
        if (!cand_occ)               state_nxt = DONE;
        else if (probe_nxt == 7'(NC)) state_nxt = FULL;
      end
      DONE:    state_nxt = IDLE;
      FULL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      body_snap  <= '0;
      cand_idx   <= '0;
      cand_x     <= '0;
      cand_y     <= '0;
      probe_cnt  <= '0;
      o_Full     <= 1'b0;
      o_Food_X   <= '0;
      o_Food_Y   <= '0;
      o_Food_Idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_Req) begin
            body_snap <= i_Body;
            cand_idx  <= start_idx;
            cand_x    <= start_xy.x;
            cand_y    <= start_xy.y;
            probe_cnt <= '0;
            o_Full    <= 1'b0;
          end
        end
        SCAN: begin
          if (!cand_occ) begin
            o_Food_Idx <= cand_idx;
            o_Food_X   <= cand_x;
            o_Food_Y   <= cand_y;
          end else begin
            probe_cnt <= probe_nxt;
            if (probe_nxt == 7'(NC)) o_Full <= 1'b1;
            // Raster-order step with wrap from the last cell back to the origin.
            if (cand_idx == 7'(NC - 1)) begin
              cand_idx <= '0;
              cand_x   <= '0;
              cand_y   <= '0;
            end else if (cand_x == 4'(GRID_W - 1)) begin
              cand_idx <= cand_idx + 7'd1;
              cand_x   <= '0;
              cand_y   <= cand_y + 4'd1;
            end else begin
              cand_idx <= cand_idx + 7'd1;
              cand_x   <= cand_x + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_Busy  = (state != IDLE);
  assign o_Valid = (state == DONE) || (state == FULL);

endmodule

// File: tb/tb_snake_food_gen.sv
// Directed bench for snake_food_gen: reset-relative vector table plus
// hand-written sequences for full board, held request, mid-scan reset and snapshot.
module tb_snake_food_gen;

  logic        i_Clk = 1'b0;
  logic        i_Rst_L;
  logic        i_Req;
  logic [89:0] i_Body;
  logic        o_Busy, o_Valid, o_Full;
  logic [3:0]  o_Food_X, o_Food_Y;
  logic [6:0]  o_Food_Idx;

  always #5 i_Clk = ~i_Clk;

  snake_food_gen dut (
    .i_Clk      (i_Clk),
    .i_Rst_L    (i_Rst_L),
    .i_Req      (i_Req),
    .i_Body     (i_Body),
    .o_Busy     (o_Busy),
    .o_Valid    (o_Valid),
    .o_Full     (o_Full),
    .o_Food_X   (o_Food_X),
    .o_Food_Y   (o_Food_Y),
    .o_Food_Idx (o_Food_Idx)
  );

  typedef struct {
    string       name;
    logic [89:0] body;
    int          idx, x, y, full, lat;
  } vec_t;

  vec_t vecs[8];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_Clk);
    #1;
  endtask

  task automatic do_reset;
    i_Rst_L = 1'b0;
    i_Req   = 1'b0;
    tick;
    tick;
  endtask

  function automatic logic [89:0] rng(input int lo, input int hi);
    logic [89:0] b;
    b = '0;
    for (int i = lo; i <= hi; i++) b[i] = 1'b1;
    return b;
  endfunction

  // Accept a request at the next edge, then wait (bounded) for o_Valid.
  // lat = cycle of o_Valid relative to accept cycle N; -1 on timeout.
  task automatic run_req(input logic [89:0] body, output int lat);
    i_Body = body;
    i_Req  = 1'b1;
    tick;
    i_Req  = 1'b0;
    lat    = -1;
    for (int c = 1; c <= 200; c++) begin
      tick;
      if (o_Valid) begin
        lat = c + 1;
        break;
      end
    end
  endtask

  initial begin
    int lat, first, nvalid, nidle;
    logic [89:0] all1;
    all1 = rng(0, 89);

    vecs[0] = '{"empty",      '0,                         45, 5, 4, 0, 2};
    vecs[1] = '{"b42_44",     rng(42, 44),                45, 5, 4, 0, 2};
    vecs[2] = '{"b45",        rng(45, 45),                46, 6, 4, 0, 3};
    vecs[3] = '{"b45_48",     rng(45, 48),                49, 9, 4, 0, 6};
    vecs[4] = '{"rowwrap",    rng(45, 49),                50, 0, 5, 0, 7};
    vecs[5] = '{"idxwrap",    rng(45, 89),                 0, 0, 0, 0, 47};
    vecs[6] = '{"only44",     all1 & ~rng(44, 44),        44, 4, 4, 0, 91};
    vecs[7] = '{"allfull",    all1,                        0, 0, 0, 1, 91};

    i_Body = '0;
    do_reset;
    chk("rst_busy",  int'(o_Busy),     0);
    chk("rst_valid", int'(o_Valid),    0);
    chk("rst_full",  int'(o_Full),     0);
    chk("rst_idx",   int'(o_Food_Idx), 0);
    chk("rst_xy",    int'({o_Food_X, o_Food_Y}), 0);

    // Every vector requests in the first cycle after reset, so the start cell is the seed (45).
    for (int v = 0; v < 8; v++) begin
      do_reset;
      i_Rst_L = 1'b1;
      run_req(vecs[v].body, lat);
      chk({vecs[v].name, "_lat"},  lat,               vecs[v].lat);
      chk({vecs[v].name, "_idx"},  int'(o_Food_Idx),  vecs[v].idx);
      chk({vecs[v].name, "_x"},    int'(o_Food_X),    vecs[v].x);
      chk({vecs[v].name, "_y"},    int'(o_Food_Y),    vecs[v].y);
      chk({vecs[v].name, "_full"}, int'(o_Full),      vecs[v].full);
      tick;
      chk({vecs[v].name, "_pulse"}, int'(o_Valid),    0);
      chk({vecs[v].name, "_idle"},  int'(o_Busy),     0);
    end

    // Full board keeps previous food, o_Full holds until next accept.
    do_reset;
    i_Rst_L = 1'b1;
    run_req('0, lat);
    tick;
    run_req(all1, lat);
    chk("full_lat",  lat,              91);
    chk("full_flag", int'(o_Full),     1);
    chk("full_keep", int'(o_Food_Idx), 45);
    chk("full_kxy",  int'({o_Food_X, o_Food_Y}), 8'h54);
    tick;
    chk("full_hold", int'(o_Full),     1);
    i_Body = '0;
    i_Req  = 1'b1;
    tick;
    i_Req  = 1'b0;
    chk("full_clr",  int'(o_Full),     0);
    chk("full_busy", int'(o_Busy),     1);

    // Request held high against a full board: one search per IDLE visit.
    do_reset;
    i_Rst_L = 1'b1;
    i_Body  = all1;
    i_Req   = 1'b1;
    tick;
    first = -1; nvalid = 0; nidle = 0;
    for (int c = 1; c <= 99; c++) begin
      tick;
      if (o_Valid) begin
        nvalid++;
        if (first < 0) first = c + 1;
      end
      if (!o_Busy) nidle++;
    end
    i_Req = 1'b0;
    chk("hold_first",  first,  91);
    chk("hold_nvalid", nvalid, 1);
    chk("hold_nidle",  nidle,  1);

    // Reset at N+10 of a long scan discards it and restarts from the seed.
    do_reset;
    i_Rst_L = 1'b1;
    run_req('0, lat);
    tick;
    i_Body = all1;
    i_Req  = 1'b1;
    tick;
    i_Req  = 1'b0;
    nvalid = 0;
    for (int c = 1; c <= 9; c++) begin
      tick;
      if (o_Valid) nvalid++;
    end
    i_Rst_L = 1'b0;
    tick;
    if (o_Valid) nvalid++;
    chk("mid_novalid", nvalid,            0);
    chk("mid_busy",    int'(o_Busy),      0);
    chk("mid_full",    int'(o_Full),      0);
    chk("mid_idx",     int'(o_Food_Idx),  0);
    chk("mid_xy",      int'({o_Food_X, o_Food_Y}), 0);
    i_Rst_L = 1'b1;
    run_req(rng(42, 44), lat);
    chk("mid_relat",   lat,               2);
    chk("mid_reidx",   int'(o_Food_Idx),  45);

    // Body changes after the snapshot are ignored.
    do_reset;
    i_Rst_L = 1'b1;
    i_Body  = '0;
    i_Req   = 1'b1;
    tick;
    i_Req   = 1'b0;
    i_Body  = all1;
    tick;
    chk("snap_valid", int'(o_Valid),     1);
    chk("snap_idx",   int'(o_Food_Idx),  45);
    chk("snap_full",  int'(o_Full),      0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
